multiple_seq: RTL and testbench
===============================

Name: multiple_seq

Overview:
- Sequencer for Thumb PUSH/POP/LDM/STM. It sits directly upstream of the multiple-transfer delay and enable stage.
- Accepts one decoded instruction, then issues one register/memory-address pair per cycle: lowest register first, at the lowest address, addresses ascending.
- Produces the pulse, stable, vector and remaining-list signals that the downstream stage uses to generate memory and register write enables.
- Finishes with a single base-register writeback cycle. Holds the core stalled via busy for the whole sequence.

Parameters:
- ADDR_W, 32, data-memory address and base value width
- LIST_W, 10, remaining-list width; [7:0] = R0-R7, [8] = LR (PUSH) or PC (POP), [9] reserved, always 0

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- start  in  1  decoder requests a multiple transfer this cycle
- ins16  in  16  instruction halfword, valid with start
- base_value  in  ADDR_W  SP for PUSH/POP, R[ins16[10:8]] for LDM/STM, valid with start
- busy  out  1  sequence in progress; stall fetch/decode
- multiple_pulse  out  1  one-cycle marker, one cycle before the first transfer
- multiple_stable  out  1  high in every transfer cycle
- multiple_vector  out  2  latched ins16[12:11]; bit0 = 1 load, 0 store
- list  out  LIST_W  bits not yet issued, including the one on reg_addr this cycle
- reg_addr  out  4  register index of the current transfer
- dm_addr  out  ADDR_W  memory address of the current transfer
- wb_en  out  1  base writeback strobe
- wb_addr  out  4  writeback register index
- wb_data  out  ADDR_W  new base value
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Every output resets to 0; state resets to IDLE.
- All outputs are registered.
- Legal start, sampled only in IDLE:
  - ins16[15:12] == 4'b1100 (STM/LDM), or
  - ins16[15:12] == 4'b1011 with ins16[10:9] == 2'b10 (PUSH/POP).
  - Any other start is ignored. start is also ignored when not in IDLE.
- Latched on accept:
  - mask = {1'b0, R-bit or 0 for LDM/STM, ins16[7:0]}
  - n = popcount(mask)
  - vector = ins16[12:11]
  - base index: 13 for PUSH/POP, ins16[10:8] for LDM/STM
- Start address: base_value - 4n for PUSH; base_value otherwise.
- New base value: base_value - 4n for PUSH; base_value + 4n otherwise. Arithmetic is modulo 2^ADDR_W.
- FSM states: IDLE -> LOAD -> XFER (n cycles) -> WB -> IDLE.
- LOAD, one cycle:
  - multiple_pulse = 1, busy = 1, multiple_vector valid.
  - list = mask; multiple_stable = 0.
- XFER:
  - multiple_stable = 1.
  - reg_addr = index of the lowest set bit of list. Bit 8 maps to 14 for PUSH, 15 for POP.
  - dm_addr = current address.
  - On each edge, clear that bit and add 4 to the address.
  - Leave XFER in the cycle where list has a single bit set.
- WB, one cycle:
  - multiple_stable = 0, list = 0, done = 1, wb_addr = base index, wb_data = new base value.
  - wb_en = 1, except for LDM with the base register in mask (loaded value wins). STM with the base in the list still writes back.
- Return to IDLE on the next edge; busy drops there.
- Outputs held stable across cycles: multiple_vector is held from LOAD through WB. busy is high from LOAD through WB.
- Empty mask (n = 0):
  - Accepted: IDLE -> WB directly.
  - No pulse, no transfers, wb_en = 0, done = 1.
- Downstream timing contract: multiple_stable & (|list) is true in every XFER cycle, including the last, and false in WB. The delayed enable therefore covers exactly n cycles.
- Reset mid-sequence: outputs clear immediately (asynchronous). No writeback is issued, and the FSM restarts in IDLE.

Decomposition:
- Shared package:
  - register index constants SP=13, LR=14, PC=15
  - state enum IDLE/LOAD/XFER/WB
  - vector encodings: PUSH=2'b10, POP=2'b11, STM=2'b00, LDM=2'b01
  - word-size constant 4
- One natural sub-module, list_prio_enc: combinational lowest-set-bit index plus popcount over LIST_W bits, reused for n and reg_addr.

Test Plan:
- PUSH {R0,R2,LR}, ins16=0xB505, base_value=0x2000_0100:
  - pulse at t0, vector=2'b10.
  - XFER reg/addr/list: 0/0x2000_00F4/0x105, 2/0x2000_00F8/0x104, 14/0x2000_00FC/0x100.
  - WB: wb_addr=13, wb_data=0x2000_00F4, wb_en=1.
- POP {R1,PC}, 0xBD02, SP=0x2000_00F8:
  - reg 1 @0x2000_00F8, reg 15 @0x2000_00FC.
  - vector=2'b11, wb_data=0x2000_0100.
- LDM R3!,{R3,R4}, 0xCB18, base_value=0x1000:
  - reg 3 @0x1000, reg 4 @0x1004.
  - wb_en=0 in WB, done=1.
- STM R0!,{R1}, 0xC002, base_value=0x2000:
  - single XFER with stable=1, list=0x002, dm_addr=0x2000.
  - WB: wb_addr=0, wb_data=0x2004.
- Empty and ignored starts:
  - STM 0xC000 -> no pulse, no stable; done=1 one cycle later, wb_en=0.
  - start=1 with 0x4408 -> ignored, busy stays 0.
- Busy and reset:
  - second start during busy -> ignored.
  - rst asserted in the second XFER of the PUSH test -> all outputs 0 immediately, no wb_en.
  - next legal start behaves normally.

Source files
------------

// File: rtl/multiple_seq_pkg.sv
// multiple_seq_pkg
// Shared definitions for the Thumb PUSH/POP/LDM/STM sequencer:
//   - architectural register indices used by the sequencer (SP, LR, PC)
//   - word size in bytes for address stepping
//   - multiple_vector encodings (ins16[12:11])
//   - sequencer state enum
//   - base_writeback(): whether a given transfer type writes its base back
package multiple_seq_pkg;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] VEC_STM  = 2'b00;
    localparam logic [1:0] VEC_LDM  = 2'b01;
    localparam logic [1:0] VEC_PUSH = 2'b10;
    localparam logic [1:0] VEC_POP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        WB   = 2'd3
    } state_e;

    // An LDM that reloads its own base register lets the loaded value win,
    // so the base update is dropped. Every other form writes the base back.
    function automatic logic base_writeback(input logic [1:0] vec,
                                            input logic       base_listed);
        logic wb;
        wb = 1'b1;
        unique case (vec)
            VEC_LDM:                   wb = ~base_listed;
            VEC_STM, VEC_PUSH, VEC_POP: wb = 1'b1;
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/multiple_seq_list_prio_enc.sv
// list_prio_enc
// Purely combinational scan of a register list.
//   vec      in   LIST_W  register list (bit i = register slot i)
//   low_idx  out  IDX_W   index of the lowest set bit (0 when vec is empty)
//   count    out  CNT_W   number of set bits
module list_prio_enc #(
    parameter int LIST_W = 10,
    parameter int IDX_W  = $clog2(LIST_W),
    parameter int CNT_W  = $clog2(LIST_W + 1)
) (
    input  logic [LIST_W-1:0] vec,
    output logic [IDX_W-1:0]  low_idx,
    output logic [CNT_W-1:0]  count
);

    // Scanning from the top down lets the last hit (the lowest bit) win.
    always_comb begin
        low_idx = '0;
        count   = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < LIST_W; i++) begin
            count = count + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/multiple_seq.sv
// multiple_seq
// Sequencer for Thumb PUSH/POP/LDM/STM. Accepts one decoded instruction in
// IDLE, announces it with a one-cycle pulse (LOAD), issues one register /
// memory-address pair per cycle lowest register first at ascending addresses
// (XFER), then finishes with one base-writeback cycle (WB). All outputs are
// registered.
//   rst              in   asynchronous reset, active-high
//   clk              in   clock
//   start            in   decoder requests a multiple transfer
//   ins16            in   instruction halfword, valid with start
//   base_value       in   SP (PUSH/POP) or R[ins16[10:8]] (LDM/STM)
//   busy             out  sequence in progress (LOAD..WB)
//   multiple_pulse   out  high in LOAD, one cycle before the first transfer
//   multiple_stable  out  high in every transfer cycle
//   multiple_vector  out  latched ins16[12:11]; bit0 = load
//   list             out  registers not yet issued, incl. the current one
//   reg_addr         out  register index of the current transfer
//   dm_addr          out  memory address of the current transfer
//   wb_en            out  base writeback strobe
//   wb_addr          out  base register index
//   wb_data          out  new base value
//   done             out  one-cycle completion pulse (WB)
module multiple_seq #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 10
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              start,
    input  logic [15:0]       ins16,
    input  logic [ADDR_W-1:0] base_value,
    output logic              busy,
    output logic              multiple_pulse,
    output logic              multiple_stable,
    output logic [1:0]        multiple_vector,
    output logic [LIST_W-1:0] list,
    output logic [3:0]        reg_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [ADDR_W-1:0] wb_data,
    output logic              done
);

    import multiple_seq_pkg::*;

    localparam int IDX_W = $clog2(LIST_W);
    localparam int CNT_W = $clog2(LIST_W + 1);

    state_e            state_q, state_d;
    logic [LIST_W-1:0] list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] new_base_q, new_base_d;
    logic [3:0]        base_idx_q, base_idx_d;
    logic              wb_allow_q, wb_allow_d;
    logic [1:0]        vector_q, vector_d;

    logic              busy_q, busy_d;
    logic              pulse_q, pulse_d;
    logic              stable_q, stable_d;
    logic [3:0]        reg_addr_q, reg_addr_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        wb_addr_q, wb_addr_d;
    logic [ADDR_W-1:0] wb_data_q, wb_data_d;
    logic              done_q, done_d;

    logic              is_ldm_stm;
    logic              is_push_pop;
    logic              accept;
    logic [7:0]        low_regs;
    logic [LIST_W-1:0] mask_in;
    logic [IDX_W-1:0]  low_idx;
    logic [CNT_W-1:0]  set_cnt;
    logic [ADDR_W-1:0] four_n;

    assign is_ldm_stm  = (ins16[15:12] == 4'b1100);
    assign is_push_pop = (ins16[15:12] == 4'b1011) && (ins16[10:9] == 2'b10);
    assign accept      = start && (state_q == IDLE) && (is_ldm_stm || is_push_pop);
    assign low_regs    = ins16[7:0];
    // Bit 8 (LR/PC) only exists for PUSH/POP; bit 9 is reserved and stays 0.
    assign mask_in     = LIST_W'({is_push_pop & ins16[8], ins16[7:0]});

    // The encoder watches the next list value: in IDLE that is the incoming
    // mask (giving n), in XFER it is the list for the next transfer cycle
    // (giving the next reg_addr).
    list_prio_enc #(
        .LIST_W (LIST_W),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) u_list_prio_enc (
        .vec     (list_d),
        .low_idx (low_idx),
        .count   (set_cnt)
    );

    assign four_n = ADDR_W'(set_cnt) * ADDR_W'(WORD_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            new_base_q <= '0;
            base_idx_q <= '0;
            wb_allow_q <= 1'b0;
            vector_q   <= '0;
            busy_q     <= 1'b0;
            pulse_q    <= 1'b0;
            stable_q   <= 1'b0;
            reg_addr_q <= '0;
            dm_addr_q  <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            new_base_q <= new_base_d;
            base_idx_q <= base_idx_d;
            wb_allow_q <= wb_allow_d;
            vector_q   <= vector_d;
            busy_q     <= busy_d;
            pulse_q    <= pulse_d;
            stable_q   <= stable_d;
            reg_addr_q <= reg_addr_d;
            dm_addr_q  <= dm_addr_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
        end
    end

    // Kept apart from the next-state block because the encoder reads list_d
    // and the next-state block reads the encoder's count.
    // Clearing the lowest set bit is list & (list - 1); the list reaching zero
    // is exactly the "last transfer" condition.
    always_comb begin
        list_d = '0;
        unique case (state_q)
            IDLE: if (accept) list_d = mask_in;
            LOAD: list_d = list_q;
            XFER: list_d = list_q & (list_q - LIST_W'(1));
            WB:   list_d = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        new_base_d = new_base_q;
        base_idx_d = base_idx_q;
        wb_allow_d = wb_allow_q;
        vector_d   = vector_q;
        unique case (state_q)
            IDLE: begin
                vector_d   = '0;
                wb_allow_d = 1'b0;
                if (accept) begin
                    vector_d   = ins16[12:11];
                    base_idx_d = is_push_pop ? REG_SP : {1'b0, ins16[10:8]};
                    if (is_push_pop && (ins16[12:11] == VEC_PUSH)) begin
                        addr_d     = base_value - four_n;
                        new_base_d = base_value - four_n;
                    end else begin
                        addr_d     = base_value;
                        new_base_d = base_value + four_n;
                    end
                    wb_allow_d = (set_cnt != '0) &&
                                 base_writeback(ins16[12:11],
                                                is_ldm_stm && low_regs[ins16[10:8]]);
                    state_d    = (set_cnt == '0) ? WB : LOAD;
                end
            end
            LOAD: state_d = XFER;
            XFER: begin
                addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                state_d = (list_d == '0) ? WB : XFER;
            end
            WB: begin
                state_d  = IDLE;
                vector_d = '0;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        busy_d     = (state_d != IDLE);
        pulse_d    = (state_d == LOAD);
        stable_d   = (state_d == XFER);
        reg_addr_d = '0;
        dm_addr_d  = '0;
        wb_en_d    = 1'b0;
        wb_addr_d  = '0;
        wb_data_d  = '0;
        done_d     = 1'b0;
        if (state_d == XFER) begin
            dm_addr_d = addr_d;
            // Slot 8 is LR when pushing and PC when popping.
            if (low_idx == IDX_W'(8)) begin
                reg_addr_d = (vector_d == VEC_POP) ? REG_PC : REG_LR;
            end else begin
                reg_addr_d = 4'(low_idx);
            end
        end
        if (state_d == WB) begin
            wb_en_d   = wb_allow_d;
            wb_addr_d = base_idx_d;
            wb_data_d = new_base_d;
            done_d    = 1'b1;
        end
    end

    assign busy            = busy_q;
    assign multiple_pulse  = pulse_q;
    assign multiple_stable = stable_q;
    assign multiple_vector = vector_q;
    assign list            = list_q;
    assign reg_addr        = reg_addr_q;
    assign dm_addr         = dm_addr_q;
    assign wb_en           = wb_en_q;
    assign wb_addr         = wb_addr_q;
    assign wb_data         = wb_data_q;
    assign done            = done_q;

endmodule

// File: tb/tb_multiple_seq.sv
// tb_multiple_seq
// Self-checking bench for multiple_seq: a table of hand-derived transactions,
// hand-written busy/reset sequences, and randomized instructions checked
// against a behavioural model of the sequencing rules.
module tb_multiple_seq;

    logic        rst;
    logic        clk;
    logic        start;
    logic [15:0] ins16;
    logic [31:0] base_value;
    logic        busy;
    logic        multiple_pulse;
    logic        multiple_stable;
    logic [1:0]  multiple_vector;
    logic [9:0]  list;
    logic [3:0]  reg_addr;
    logic [31:0] dm_addr;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct packed {
        logic [15:0]      ins;
        logic [31:0]      base;
        logic             legal;
        logic [3:0]       n;
        logic [1:0]       vec;
        logic             wb_en;
        logic [3:0]       wb_addr;
        logic [31:0]      wb_data;
        logic [8:0][3:0]  regs;
        logic [8:0][31:0] addrs;
        logic [8:0][9:0]  lists;
    } exp_t;

    multiple_seq #(
        .ADDR_W (32),
        .LIST_W (10)
    ) dut (
        .rst             (rst),
        .clk             (clk),
        .start           (start),
        .ins16           (ins16),
        .base_value      (base_value),
        .busy            (busy),
        .multiple_pulse  (multiple_pulse),
        .multiple_stable (multiple_stable),
        .multiple_vector (multiple_vector),
        .list            (list),
        .reg_addr        (reg_addr),
        .dm_addr         (dm_addr),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkCycle(input string tag, input logic busy_e,
                              input logic pulse_e, input logic stable_e,
                              input logic [9:0] list_e, input logic wb_en_e,
                              input logic done_e, input logic [1:0] vec_e);
        checkOutput({tag, " busy"},   32'(busy),            32'(busy_e));
        checkOutput({tag, " pulse"},  32'(multiple_pulse),  32'(pulse_e));
        checkOutput({tag, " stable"}, 32'(multiple_stable), 32'(stable_e));
        checkOutput({tag, " list"},   32'(list),            32'(list_e));
        checkOutput({tag, " wb_en"},  32'(wb_en),           32'(wb_en_e));
        checkOutput({tag, " done"},   32'(done),            32'(done_e));
        if (busy_e) checkOutput({tag, " vector"}, 32'(multiple_vector), 32'(vec_e));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"},     32'(busy),            32'd0);
        checkOutput({tag, " pulse"},    32'(multiple_pulse),  32'd0);
        checkOutput({tag, " stable"},   32'(multiple_stable), 32'd0);
        checkOutput({tag, " vector"},   32'(multiple_vector), 32'd0);
        checkOutput({tag, " list"},     32'(list),            32'd0);
        checkOutput({tag, " reg_addr"}, 32'(reg_addr),        32'd0);
        checkOutput({tag, " dm_addr"},  dm_addr,              32'd0);
        checkOutput({tag, " wb_en"},    32'(wb_en),           32'd0);
        checkOutput({tag, " wb_addr"},  32'(wb_addr),         32'd0);
        checkOutput({tag, " wb_data"},  wb_data,              32'd0);
        checkOutput({tag, " done"},     32'(done),            32'd0);
    endtask

    // Behavioural model: walk the register mask from bit 0 upward, one word
    // per register, starting below the base for PUSH and at the base otherwise.
    function automatic exp_t buildExpect(input logic [15:0] ins, input logic [31:0] base);
        exp_t        e;
        logic        pp;
        logic        push;
        logic [8:0]  bits;
        logic [7:0]  lo;
        logic [9:0]  rem;
        logic [31:0] span;
        logic [31:0] first;
        int          k;
        e      = '0;
        e.ins  = ins;
        e.base = base;
        pp     = (ins[15:12] == 4'hB);
        push   = pp && !ins[11];
        e.legal = (ins[15:12] == 4'hC) || (pp && ins[10:9] == 2'b10);
        e.vec  = ins[12:11];
        bits   = {pp & ins[8], ins[7:0]};
        lo     = ins[7:0];
        rem    = {1'b0, bits};
        k      = 0;
        for (int b = 0; b < 9; b++) begin
            if (bits[b]) begin
                e.lists[k] = rem;
                e.regs[k]  = (b == 8) ? (ins[11] ? 4'd15 : 4'd14) : 4'(b);
                rem[b]     = 1'b0;
                k++;
            end
        end
        e.n     = 4'(k);
        span    = 32'(k) * 32'd4;
        first   = push ? base - span : base;
        for (int j = 0; j < k; j++) e.addrs[j] = first + 32'(j) * 32'd4;
        e.wb_addr = pp ? 4'd13 : {1'b0, ins[10:8]};
        e.wb_data = push ? base - span : base + span;
        e.wb_en   = (k > 0) && !(!pp && ins[11] && lo[ins[10:8]]);
        return e;
    endfunction

    function automatic exp_t mkVec(input logic [15:0] ins, input logic [31:0] base,
                                   input logic legal, input logic [3:0] n,
                                   input logic [1:0] vec, input logic wben,
                                   input logic [3:0] wbaddr, input logic [31:0] wbdata,
                                   input logic [11:0] r3, input logic [95:0] a3,
                                   input logic [29:0] l3);
        exp_t e;
        e              = '0;
        e.ins          = ins;
        e.base         = base;
        e.legal        = legal;
        e.n            = n;
        e.vec          = vec;
        e.wb_en        = wben;
        e.wb_addr      = wbaddr;
        e.wb_data      = wbdata;
        e.regs[2:0]    = r3;
        e.addrs[2:0]   = a3;
        e.lists[2:0]   = l3;
        return e;
    endfunction

    // Drives one start and follows the whole expected trace cycle by cycle.
    // With poke set, a second legal start is driven while the sequencer is busy.
    task automatic applyStimulus(input exp_t e, input string tag, input bit poke);
        @(negedge clk);
        start      = 1'b1;
        ins16      = e.ins;
        base_value = e.base;
        @(negedge clk);
        start      = 1'b0;
        ins16      = 16'hC0FF;
        base_value = ~e.base;
        if (!e.legal) begin
            checkCycle({tag, " ignored"}, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 2'b00);
            @(negedge clk);
            checkCycle({tag, " ignored+1"}, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 2'b00);
            return;
        end
        if (e.n != 0) begin
            checkCycle({tag, " load"}, 1'b1, 1'b1, 1'b0, e.lists[0], 1'b0, 1'b0, e.vec);
            if (poke) begin
                start      = 1'b1;
                ins16      = 16'hC0FF;
                base_value = 32'h5555_0000;
            end
            for (int k = 0; k < int'(e.n); k++) begin
                @(negedge clk);
                if (poke && k == 0) start = 1'b0;
                checkCycle($sformatf("%s xfer%0d", tag, k), 1'b1, 1'b0, 1'b1,
                           e.lists[k], 1'b0, 1'b0, e.vec);
                checkOutput($sformatf("%s xfer%0d reg_addr", tag, k), 32'(reg_addr), 32'(e.regs[k]));
                checkOutput($sformatf("%s xfer%0d dm_addr", tag, k), dm_addr, e.addrs[k]);
            end
            @(negedge clk);
        end
        checkCycle({tag, " wb"}, 1'b1, 1'b0, 1'b0, 10'd0, e.wb_en, 1'b1, e.vec);
        checkOutput({tag, " wb_addr"}, 32'(wb_addr), 32'(e.wb_addr));
        checkOutput({tag, " wb_data"}, wb_data, e.wb_data);
        @(negedge clk);
        checkCycle({tag, " idle"}, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 2'b00);
    endtask

    exp_t tbl[9];

    initial begin
        exp_t        e;
        logic [15:0] rins;
        int          kind;

        tbl[0] = mkVec(16'hB505, 32'h2000_0100, 1'b1, 4'd3, 2'b10, 1'b1, 4'd13, 32'h2000_00F4,
                       {4'd14, 4'd2, 4'd0},
                       {32'h2000_00FC, 32'h2000_00F8, 32'h2000_00F4},
                       {10'h100, 10'h104, 10'h105});
        tbl[1] = mkVec(16'hBD02, 32'h2000_00F8, 1'b1, 4'd2, 2'b11, 1'b1, 4'd13, 32'h2000_0100,
                       {4'd0, 4'd15, 4'd1},
                       {32'h0, 32'h2000_00FC, 32'h2000_00F8},
                       {10'h000, 10'h100, 10'h102});
        tbl[2] = mkVec(16'hCB18, 32'h0000_1000, 1'b1, 4'd2, 2'b01, 1'b0, 4'd3, 32'h0000_1008,
                       {4'd0, 4'd4, 4'd3},
                       {32'h0, 32'h0000_1004, 32'h0000_1000},
                       {10'h000, 10'h010, 10'h018});
        tbl[3] = mkVec(16'hC002, 32'h0000_2000, 1'b1, 4'd1, 2'b00, 1'b1, 4'd0, 32'h0000_2004,
                       {4'd0, 4'd0, 4'd1},
                       {32'h0, 32'h0, 32'h0000_2000},
                       {10'h000, 10'h000, 10'h002});
        tbl[4] = mkVec(16'hC000, 32'h0000_3000, 1'b1, 4'd0, 2'b00, 1'b0, 4'd0, 32'h0000_3000,
                       12'd0, 96'd0, 30'd0);
        tbl[5] = mkVec(16'h4408, 32'h0000_4000, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 32'h0,
                       12'd0, 96'd0, 30'd0);
        tbl[6] = mkVec(16'hB480, 32'h0000_0002, 1'b1, 4'd1, 2'b10, 1'b1, 4'd13, 32'hFFFF_FFFE,
                       {4'd0, 4'd0, 4'd7},
                       {32'h0, 32'h0, 32'hFFFF_FFFE},
                       {10'h000, 10'h000, 10'h080});
        tbl[7] = mkVec(16'hC284, 32'h0000_4000, 1'b1, 4'd2, 2'b00, 1'b1, 4'd2, 32'h0000_4008,
                       {4'd0, 4'd7, 4'd2},
                       {32'h0, 32'h0000_4004, 32'h0000_4000},
                       {10'h000, 10'h080, 10'h084});
        tbl[8] = mkVec(16'hB600, 32'h0000_5000, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 32'h0,
                       12'd0, 96'd0, 30'd0);

        rst        = 1'b1;
        start      = 1'b0;
        ins16      = 16'h0000;
        base_value = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i], $sformatf("tbl%0d", i), 1'b0);
        end

        applyStimulus(tbl[0], "busy_poke", 1'b1);

        // Reset asserted while the PUSH is in its second transfer cycle.
        @(negedge clk);
        start      = 1'b1;
        ins16      = tbl[0].ins;
        base_value = tbl[0].base;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst pre reg_addr", 32'(reg_addr), 32'd2);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkCycle($sformatf("postrst%0d", c), 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 2'b00);
        end
        applyStimulus(tbl[1], "after_rst", 1'b0);

        for (int r = 0; r < 60; r++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)      rins = {4'hC, 12'($urandom)};
            else if (kind == 1) rins = {4'hB, 1'($urandom), 2'b10, 9'($urandom)};
            else                rins = 16'($urandom);
            e = buildExpect(rins, $urandom);
            applyStimulus(e, $sformatf("rnd%0d_%04h", r, rins), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
